// File: rtl/mult_control_pkg.sv
// Shared state encoding for the repeated-addition multiplier control FSM.
// The datapath and the bench import these constants to decode or print states.
package mult_control_pkg;

  localparam int unsigned STATE_W = 3;

  localparam logic [STATE_W-1:0] ST_IDLE  = 3'd0;
  localparam logic [STATE_W-1:0] ST_CLEAR = 3'd1;
  localparam logic [STATE_W-1:0] ST_WAIT  = 3'd2;
  localparam logic [STATE_W-1:0] ST_CHECK = 3'd3;
  localparam logic [STATE_W-1:0] ST_ADD   = 3'd4;
  localparam logic [STATE_W-1:0] ST_DECR  = 3'd5;
  localparam logic [STATE_W-1:0] ST_DONE  = 3'd6;

  // Operation in progress: everything from CLEAR through DECR.
  function automatic logic state_is_busy(input logic [STATE_W-1:0] s);
    return (s == ST_CLEAR) || (s == ST_WAIT) || (s == ST_CHECK) ||
           (s == ST_ADD) || (s == ST_DECR);
  endfunction

endpackage

// File: rtl/mult_control.sv
// Moore FSM sequencing an accumulator/down-counter datapath to multiply by repeated
// addition, with start/ready and done/ack handshakes, abort and an iteration watchdog.
module mult_control
  import mult_control_pkg::*;
#(
  parameter int unsigned CNT_W    = 4,
  parameter int unsigned MAX_ITER = (1 << CNT_W) - 1
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic abort,
  input  logic ack,
  input  logic zero,
  output logic ready,
  output logic busy,
  output logic rac,
  output logic cac,
  output logic set,
  output logic dec,
  output logic done,
  output logic err
);

  localparam logic [CNT_W-1:0] LP_MAX_ITER = CNT_W'(MAX_ITER);

  logic [STATE_W-1:0] r_state;
  logic [STATE_W-1:0] w_state_next;
  logic [CNT_W-1:0]   r_iter;
  logic [CNT_W-1:0]   w_iter_next;
  logic               r_err;
  logic               w_err_next;

  always_comb begin
    w_state_next = r_state;
    w_iter_next  = r_iter;
    w_err_next   = r_err;
    case (r_state)
      ST_IDLE: begin
        if (!abort && start) begin
          w_state_next = ST_CLEAR;
          w_iter_next  = '0;
          w_err_next   = 1'b0;
        end
      end
      ST_CLEAR: w_state_next = abort ? ST_IDLE : ST_WAIT;
      // WAIT gives the registered zero flag one cycle to follow the counter.
      ST_WAIT:  w_state_next = abort ? ST_IDLE : ST_CHECK;
      ST_CHECK: begin
        if (abort) begin
          w_state_next = ST_IDLE;
        end else if (zero) begin
          w_state_next = ST_DONE;
        end else if (r_iter == LP_MAX_ITER) begin
          // Compare precedes increment, so iter never wraps.
          w_state_next = ST_DONE;
          w_err_next   = 1'b1;
        end else begin
          w_state_next = ST_ADD;
        end
      end
      ST_ADD: begin
        if (abort) begin
          w_state_next = ST_IDLE;
        end else begin
          w_state_next = ST_DECR;
          w_iter_next  = r_iter + CNT_W'(1);
        end
      end
      ST_DECR:  w_state_next = abort ? ST_IDLE : ST_WAIT;
      ST_DONE:  w_state_next = ack ? ST_IDLE : ST_DONE;
      default:  w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_iter  <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_iter  <= w_iter_next;
      r_err   <= w_err_next;
    end
  end

  always_comb begin
    ready = 1'b0;
    rac   = 1'b0;
    cac   = 1'b0;
    set   = 1'b0;
    dec   = 1'b0;
    done  = 1'b0;
    case (r_state)
      ST_IDLE:  ready = 1'b1;
      ST_CLEAR: begin
        rac = 1'b1;
        set = 1'b1;
      end
      ST_ADD:   cac  = 1'b1;
      ST_DECR:  dec  = 1'b1;
      ST_DONE:  done = 1'b1;
      default:  ;
    endcase
  end

  assign busy = state_is_busy(r_state);
  assign err  = r_err;

endmodule

// File: tb/tb_mult_control.sv
// Self-checking bench: behavioural datapath plus a timing-schedule reference model of the
// controller, compared every cycle, with directed scenarios pinned by literal expectations.
module tb_mult_control;

  localparam int unsigned CNT_W    = 4;
  localparam int unsigned MAX_ITER = 15;

  logic clk = 1'b0;
  logic rst, start, abort, ack, zero;
  logic ready, busy, rac, cac, set, dec, done, err;

  always #5 clk = ~clk;

  mult_control #(.CNT_W(CNT_W), .MAX_ITER(MAX_ITER)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .ack(ack), .zero(zero),
    .ready(ready), .busy(busy), .rac(rac), .cac(cac), .set(set), .dec(dec),
    .done(done), .err(err)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Datapath: down-counter, registered zero flag (one cycle behind), accumulator.
  logic [3:0] operand, valor;
  bit         stuck;
  logic [3:0] dp_cnt;
  logic       dp_zero_q;
  logic [7:0] dp_acc;

  assign zero = stuck ? 1'b0 : dp_zero_q;

  always @(posedge clk) begin
    if (rst) begin
      dp_cnt    <= '0;
      dp_zero_q <= 1'b1;
      dp_acc    <= '0;
    end else begin
      if (set) dp_cnt <= operand;
      else if (dec) dp_cnt <= dp_cnt - 4'd1;
      dp_zero_q <= (dp_cnt == 4'd0);
      if (rac) dp_acc <= '0;
      else if (cac) dp_acc <= dp_acc + 8'(valor);
    end
  end

  // Reference model: phase 0 idle, 1 running, 2 done. t counts edges since accept;
  // an operation of k additions shows CLEAR at t=1, ADD at t=4j, DECR at t=4j+1 (j=1..k),
  // and done from t=4k+4.
  int m_phase = 0;
  int m_t     = 0;
  int m_iters = 0;
  int m_n     = 0;
  int m_v     = 0;
  bit m_err   = 0;
  bit m_stuck = 0;
  bit m_enter_done = 0;

  always @(posedge clk) begin
    m_enter_done = 0;
    if (rst) begin
      m_phase = 0;
      m_err   = 0;
    end else begin
      case (m_phase)
        0: if (start && !abort) begin
          m_phase = 1;
          m_t     = 1;
          m_stuck = stuck;
          m_iters = stuck ? int'(MAX_ITER) : int'(operand);
          m_n     = int'(operand);
          m_v     = int'(valor);
          m_err   = 0;
        end
        1: if (abort) begin
          m_phase = 0;
        end else begin
          m_t++;
          if (m_t == 4 * m_iters + 4) begin
            m_phase      = 2;
            m_err        = m_stuck;
            m_enter_done = 1;
          end
        end
        default: if (ack) m_phase = 0;
      endcase
    end
  end

  function automatic logic [7:0] model_vec();
    logic run;
    run = (m_phase == 1);
    return {m_phase == 0, run, run && m_t == 1, run && m_t >= 4 && m_t % 4 == 0,
            run && m_t == 1, run && m_t >= 5 && m_t % 4 == 1, m_phase == 2, m_err};
  endfunction

  always begin
    @(posedge clk);
    #1;
    check("outputs{ready,busy,rac,cac,set,dec,done,err}",
          32'({ready, busy, rac, cac, set, dec, done, err}), 32'(model_vec()));
    if (m_enter_done && !m_stuck) check("soma", 32'(dp_acc), 32'(m_n * m_v));
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Accepts one operation and waits (bounded) until done; leaves the DUT in DONE.
  task automatic run_op(input logic [3:0] n, input logic [3:0] v, input bit stk,
                        output int cyc, output int ncac, output int ndec);
    bit got;
    operand = n;
    valor   = v;
    stuck   = stk;
    start   = 1'b1;
    step();
    start = 1'b0;
    cyc = 0; ncac = 0; ndec = 0; got = 0;
    for (int i = 0; i < 200 && !got; i++) begin
      cyc++;
      if (cac) ncac++;
      if (dec) ndec++;
      if (done) got = 1;
      else step();
    end
    if (!got) check("done_timeout", 32'(0), 32'(1));
  endtask

  task automatic do_ack();
    ack = 1'b1;
    step();
    ack = 1'b0;
  endtask

  int  cyc, ncac, ndec;
  bit  seen;

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0; ack = 1'b0;
    operand = '0; valor = '0; stuck = 0;
    step();
    step();
    check("reset_outputs", 32'({ready, busy, rac, cac, set, dec, done, err}), 32'h80);
    rst = 1'b0;
    step();

    // 1: 3 x 5
    run_op(4'd3, 4'd5, 0, cyc, ncac, ndec);
    check("t1_latency", 32'(cyc), 32'd16);
    check("t1_cac", 32'(ncac), 32'd3);
    check("t1_dec", 32'(ndec), 32'd3);
    check("t1_soma", 32'(dp_acc), 32'd15);
    check("t1_err", 32'(err), 32'd0);
    do_ack();

    // 2: operand 0
    run_op(4'd0, 4'd7, 0, cyc, ncac, ndec);
    check("t2_latency", 32'(cyc), 32'd4);
    check("t2_cac", 32'(ncac), 32'd0);
    check("t2_soma", 32'(dp_acc), 32'd0);
    do_ack();

    // 3: abort in the first ADD
    operand = 4'd2; valor = 4'd9; start = 1'b1;
    step();
    start = 1'b0;
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      if (cac) seen = 1;
      else step();
    end
    check("t3_reached_add", 32'(seen), 32'd1);
    abort = 1'b1;
    step();
    abort = 1'b0;
    check("t3_ready_after_abort", 32'({ready, busy}), 32'b10);
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      if (done) seen = 1;
      step();
    end
    check("t3_no_done", 32'(seen), 32'd0);
    run_op(4'd2, 4'd3, 0, cyc, ncac, ndec);
    check("t3_rerun_soma", 32'(dp_acc), 32'd6);
    check("t3_rerun_latency", 32'(cyc), 32'd12);

    // 4: done held with start/abort noise, then ack
    do_ack();
    run_op(4'd1, 4'd4, 0, cyc, ncac, ndec);
    for (int i = 0; i < 5; i++) begin
      start = (i % 2 == 0);
      abort = (i % 2 == 1);
      step();
      check("t4_done_held", 32'(done), 32'd1);
    end
    start = 1'b0; abort = 1'b0;
    do_ack();
    check("t4_idle_after_ack", 32'({ready, done}), 32'b10);

    // 5: stuck datapath trips the watchdog; next start clears err
    run_op(4'd3, 4'd1, 1, cyc, ncac, ndec);
    check("t5_cac", 32'(ncac), 32'd15);
    check("t5_latency", 32'(cyc), 32'd64);
    check("t5_err", 32'(err), 32'd1);
    do_ack();
    check("t5_err_kept_idle", 32'(err), 32'd1);
    run_op(4'd1, 4'd2, 0, cyc, ncac, ndec);
    check("t5_err_cleared", 32'(err), 32'd0);
    do_ack();

    // 6: reset during DECR, then start+abort together
    operand = 4'd3; valor = 4'd2; start = 1'b1;
    step();
    start = 1'b0;
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      if (dec) seen = 1;
      else step();
    end
    check("t6_reached_decr", 32'(seen), 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("t6_reset_outputs", 32'({ready, busy, rac, cac, set, dec, done, err}), 32'h80);
    start = 1'b1; abort = 1'b1;
    step();
    start = 1'b0; abort = 1'b0;
    check("t6_abort_wins", 32'({ready, busy}), 32'b10);

    // Randomized traffic against the model.
    for (int i = 0; i < 4000; i++) begin
      if (m_phase == 0) begin
        operand = 4'($urandom);
        valor   = 4'($urandom);
        stuck   = ($urandom % 10 == 0);
      end
      start = ($urandom % 3 == 0);
      abort = ($urandom % 40 == 0);
      ack   = ($urandom % 4 == 0);
      rst   = ($urandom % 300 == 0);
      step();
    end
    rst = 1'b0; start = 1'b0; abort = 1'b0; ack = 1'b0;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
